// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_LEN_H,
        ST_GET_LEN_L,
        ST_PAYLOAD,
        ST_CHECK
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CHK  = 2'b01;
    localparam logic [1:0] ERR_LEN  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

endpackage

// File: rtl/frame_timeout_ctr.sv
// Inter-byte idle counter; raises timeout_o when TIMEOUT_CYCLES idle cycles
// have elapsed inside a frame. Used only when FRAME_TIMEOUT_EN is defined.
module frame_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rx_done_tick_i,
    input  logic busy_i,
    output logic timeout_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (rx_done_tick_i || !busy_i) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // A byte arriving in the firing cycle suppresses the timeout.
    assign timeout_o = busy_i && !rx_done_tick_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SYNC/LEN_H/LEN_L/payload/CHK frames from a UART byte stream.
// Define FRAME_TIMEOUT_EN to abort frames that stall between bytes.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int unsigned DBIT           = 8,
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_done_tick,
    input  logic [DBIT-1:0]   rx_dout,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DBIT-1:0]   wr_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam int unsigned LW = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [DBIT-1:0]   len_h_q, len_h_d;
    logic [LW-1:0]     len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DBIT-1:0]   sum_q, sum_d;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DBIT-1:0]   wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic              busy_q, busy_d;

    logic [2*DBIT-1:0] len_full;
    logic              len_too_long;
    logic              last_byte;
    logic              timeout;

    assign len_full     = {len_h_q, rx_dout};
    assign len_too_long = 32'(len_full) > (32'd1 << ADDR_W);
    assign last_byte    = ({1'b0, idx_q} == (len_q - LW'(1)));

`ifdef FRAME_TIMEOUT_EN
    frame_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx_done_tick_i (rx_done_tick),
        .busy_i         (busy_q),
        .timeout_o      (timeout)
    );
`else
    assign timeout = 1'b0;
    // TIMEOUT_CYCLES is accepted for interface compatibility but has no effect here.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            len_h_q   <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= ERR_NONE;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_h_q   <= len_h_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_h_d = len_h_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        if (rx_done_tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_dout == DBIT'(SYNC_BYTE)) begin
                        state_d = ST_GET_LEN_H;
                        idx_d   = '0;
                        sum_d   = '0;
                    end
                end
                ST_GET_LEN_H: begin
                    len_h_d = rx_dout;
                    state_d = ST_GET_LEN_L;
                end
                ST_GET_LEN_L: begin
                    len_d = LW'(len_full);
                    if (len_too_long)        state_d = ST_IDLE;
                    else if (len_full == '0) state_d = ST_CHECK;
                    else                     state_d = ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    sum_d = sum_q + rx_dout;
                    idx_d = idx_q + ADDR_W'(1);
                    if (last_byte) state_d = ST_CHECK;
                end
                ST_CHECK: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end else if (timeout) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;
        busy_d    = (state_d != ST_IDLE);
        if (rx_done_tick) begin
            if (state_q == ST_GET_LEN_L && len_too_long) begin
                err_d  = 1'b1;
                code_d = ERR_LEN;
            end else if (state_q == ST_PAYLOAD) begin
                wr_en_d   = 1'b1;
                wr_addr_d = idx_q;
                wr_data_d = rx_dout;
            end else if (state_q == ST_CHECK) begin
                if (rx_dout == sum_q) begin
                    done_d = 1'b1;
                    code_d = ERR_NONE;
                end else begin
                    err_d  = 1'b1;
                    code_d = ERR_CHK;
                end
            end
        end else if (timeout) begin
            err_d  = 1'b1;
            code_d = ERR_TMO;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign err_code   = code_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser; two instances (ADDR_W 12 and 4).
// Define FRAME_TIMEOUT_EN to exercise the timeout path.
module tb_uart_frame_parser;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        rx_a = 1'b0;
    logic [7:0]  d_a = '0;
    logic        we_a, done_a, err_a, busy_a;
    logic [11:0] addr_a;
    logic [7:0]  data_a;
    logic [1:0]  code_a;

    logic        rx_b = 1'b0;
    logic [7:0]  d_b = '0;
    logic        we_b, done_b, err_b, busy_b;
    logic [3:0]  addr_b;
    logic [7:0]  data_b;
    logic [1:0]  code_b;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt_a = 0, done_cnt_a = 0, err_cnt_a = 0, both_cnt = 0;

    always #5 clk = ~clk;

    uart_frame_parser #(.DBIT(8), .ADDR_W(12), .TIMEOUT_CYCLES(50)) u_dut (
        .clk(clk), .reset_n(reset_n), .rx_done_tick(rx_a), .rx_dout(d_a),
        .wr_en(we_a), .wr_addr(addr_a), .wr_data(data_a),
        .frame_done(done_a), .frame_err(err_a), .err_code(code_a), .busy(busy_a)
    );

    uart_frame_parser #(.DBIT(8), .ADDR_W(4), .TIMEOUT_CYCLES(50)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .rx_done_tick(rx_b), .rx_dout(d_b),
        .wr_en(we_b), .wr_addr(addr_b), .wr_data(data_b),
        .frame_done(done_b), .frame_err(err_b), .err_code(code_b), .busy(busy_b)
    );

    always @(posedge clk) begin
        #1;
        if (we_a)   wr_cnt_a++;
        if (done_a) done_cnt_a++;
        if (err_a)  err_cnt_a++;
        if ((done_a && err_a) || (done_b && err_b)) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] b);
        @(negedge clk);
        if (sel) begin rx_b = 1'b1; d_b = b; end
        else     begin rx_a = 1'b1; d_a = b; end
        @(negedge clk);
        rx_a = 1'b0;
        rx_b = 1'b0;
    endtask

    // Sends one byte and checks the registered response one cycle later.
    task automatic send_exp(input string tag, input bit sel, input logic [7:0] b,
                            input logic we, input logic [11:0] a, input logic [7:0] d,
                            input logic done, input logic err, input logic [1:0] code,
                            input logic bsy);
        send(sel, b);
        if (!sel) begin
            check({tag, ".we"}, 32'(we_a), 32'(we));
            if (we) begin
                check({tag, ".addr"}, 32'(addr_a), 32'(a));
                check({tag, ".data"}, 32'(data_a), 32'(d));
            end
            check({tag, ".done"}, 32'(done_a), 32'(done));
            check({tag, ".err"},  32'(err_a),  32'(err));
            check({tag, ".code"}, 32'(code_a), 32'(code));
            check({tag, ".busy"}, 32'(busy_a), 32'(bsy));
        end else begin
            check({tag, ".we"}, 32'(we_b), 32'(we));
            if (we) begin
                check({tag, ".addr"}, 32'(addr_b), 32'(a[3:0]));
                check({tag, ".data"}, 32'(data_b), 32'(d));
            end
            check({tag, ".done"}, 32'(done_b), 32'(done));
            check({tag, ".err"},  32'(err_b),  32'(err));
            check({tag, ".code"}, 32'(code_b), 32'(code));
            check({tag, ".busy"}, 32'(busy_b), 32'(bsy));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".we"},   32'(we_a),   0);
        check({tag, ".addr"}, 32'(addr_a), 0);
        check({tag, ".data"}, 32'(data_a), 0);
        check({tag, ".done"}, 32'(done_a), 0);
        check({tag, ".err"},  32'(err_a),  0);
        check({tag, ".code"}, 32'(code_a), 0);
        check({tag, ".busy"}, 32'(busy_a), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, dn0, er0, n;
        bit seen;

        repeat (3) @(negedge clk);
        check_all_zero("rst");
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_rst");

        // Three-byte frame with good checksum
        wr0 = wr_cnt_a; dn0 = done_cnt_a;
        send_exp("f1.sync", 0, 8'hA5, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("f1.lenh", 0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("f1.lenl", 0, 8'h03, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("f1.p0",   0, 8'h10, 1, 0, 8'h10, 0, 0, 2'b00, 1);
        send_exp("f1.p1",   0, 8'h20, 1, 1, 8'h20, 0, 0, 2'b00, 1);
        send_exp("f1.p2",   0, 8'h30, 1, 2, 8'h30, 0, 0, 2'b00, 1);
        send_exp("f1.chk",  0, 8'h60, 0, 0, 0, 1, 0, 2'b00, 0);
        @(negedge clk);
        check("f1.wr_count",   32'(wr_cnt_a - wr0),   3);
        check("f1.done_count", 32'(done_cnt_a - dn0), 1);

        // Bad checksum, then empty frame
        send_exp("f2.sync", 0, 8'hA5, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("f2.lenh", 0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("f2.lenl", 0, 8'h02, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("f2.p0",   0, 8'h01, 1, 0, 8'h01, 0, 0, 2'b00, 1);
        send_exp("f2.p1",   0, 8'h02, 1, 1, 8'h02, 0, 0, 2'b00, 1);
        send_exp("f2.chk",  0, 8'hFF, 0, 0, 0, 0, 1, 2'b01, 0);
        send_exp("f3.sync", 0, 8'hA5, 0, 0, 0, 0, 0, 2'b01, 1);
        send_exp("f3.lenh", 0, 8'h00, 0, 0, 0, 0, 0, 2'b01, 1);
        send_exp("f3.lenl", 0, 8'h00, 0, 0, 0, 0, 0, 2'b01, 1);
        send_exp("f3.chk",  0, 8'h00, 0, 0, 0, 1, 0, 2'b00, 0);

        // Leading junk ignored, 0xA5 as payload and checksum
        send_exp("f4.j0",   0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0);
        send_exp("f4.j1",   0, 8'h5A, 0, 0, 0, 0, 0, 2'b00, 0);
        send_exp("f4.sync", 0, 8'hA5, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("f4.lenh", 0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("f4.lenl", 0, 8'h01, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("f4.p0",   0, 8'hA5, 1, 0, 8'hA5, 0, 0, 2'b00, 1);
        send_exp("f4.chk",  0, 8'hA5, 0, 0, 0, 1, 0, 2'b00, 0);

        // ADDR_W=4: LEN 17 rejected, LEN 16 accepted
        send_exp("l4.sync", 1, 8'hA5, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("l4.lenh", 1, 8'h00, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("l4.lenl", 1, 8'h11, 0, 0, 0, 0, 1, 2'b10, 0);
        @(negedge clk);
        check("l4.busy_after", 32'(busy_b), 0);
        check("l4.no_wr",      32'(we_b),   0);
        send_exp("m4.sync", 1, 8'hA5, 0, 0, 0, 0, 0, 2'b10, 1);
        send_exp("m4.lenh", 1, 8'h00, 0, 0, 0, 0, 0, 2'b10, 1);
        send_exp("m4.lenl", 1, 8'h10, 0, 0, 0, 0, 0, 2'b10, 1);
        for (int i = 0; i < 16; i++)
            send_exp($sformatf("m4.p%0d", i), 1, 8'(i), 1, 12'(i), 8'(i), 0, 0, 2'b10, 1);
        send_exp("m4.chk",  1, 8'h78, 0, 0, 0, 1, 0, 2'b00, 0);

        // Stalled frame: timeout abort when enabled, otherwise wait forever
        er0 = err_cnt_a;
        send_exp("t.sync", 0, 8'hA5, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("t.lenh", 0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("t.lenl", 0, 8'h05, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("t.p0",   0, 8'h11, 1, 0, 8'h11, 0, 0, 2'b00, 1);
`ifdef FRAME_TIMEOUT_EN
        seen = 1'b0;
        n = 0;
        for (int i = 1; i <= 200 && !seen; i++) begin
            @(negedge clk);
            if (err_a) begin seen = 1'b1; n = i; end
        end
        check("t.fired",  32'(seen), 1);
        check("t.cycle",  32'(n), 50);
        check("t.code",   32'(code_a), 2'b11);
        check("t.busy",   32'(busy_a), 0);
`else
        seen = 1'b0;
        n = 0;
        repeat (80) @(negedge clk);
        check("t.busy_held", 32'(busy_a), 1);
        check("t.no_err",    32'(err_cnt_a - er0), 0);
`endif

        // Reset mid-frame after the third payload byte of a 5-byte frame
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        er0 = err_cnt_a;
        send_exp("r.sync", 0, 8'hA5, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("r.lenh", 0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("r.lenl", 0, 8'h05, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("r.p0",   0, 8'h01, 1, 0, 8'h01, 0, 0, 2'b00, 1);
        send_exp("r.p1",   0, 8'h02, 1, 1, 8'h02, 0, 0, 2'b00, 1);
        send_exp("r.p2",   0, 8'h03, 1, 2, 8'h03, 0, 0, 2'b00, 1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("r.in_rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("r.released");
        check("r.no_err", 32'(err_cnt_a - er0), 0);
        send_exp("g.sync", 0, 8'hA5, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("g.lenh", 0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("g.lenl", 0, 8'h02, 0, 0, 0, 0, 0, 2'b00, 1);
        send_exp("g.p0",   0, 8'h07, 1, 0, 8'h07, 0, 0, 2'b00, 1);
        send_exp("g.p1",   0, 8'h08, 1, 1, 8'h08, 0, 0, 2'b00, 1);
        send_exp("g.chk",  0, 8'h0F, 0, 0, 0, 1, 0, 2'b00, 0);

        @(negedge clk);
        check("done_err_overlap", 32'(both_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
